// File: rtl/ky11_intr.sv
// ky11_intr: Unibus BR/BG/SACK/INTR interrupt requester with vector drive.
// Define KY11_INTR_TIMEOUT_EN to abandon a transaction after SSYNTIMO cycles.
module ky11_intr #(
  parameter int GRDEBOUNCE = 4,
  parameter int SSYNTIMO   = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [2:0]  irqlev,
  input  logic [5:0]  irqvec,
  input  logic        init_in_h,
  input  logic [3:0]  bg_in_l,
  input  logic        bbsy_in_h,
  input  logic        syn_msyn_in_h,
  input  logic        syn_ssyn_in_h,
  input  logic        del_ssyn_in_h,
  output logic [3:0]  br_out_h,
  output logic [3:0]  bg_out_l,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        intr_out_h,
  output logic [15:0] d_out_h,
  output logic        irqdone,
  output logic        intrtimo,
  output logic [2:0]  istate
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    GRANT    = 3'd2,
    WAITSSYN = 3'd3,
    RELEASE  = 3'd4
  } st_t;

  localparam int CW = $clog2(GRDEBOUNCE + 1);

  st_t         st_q, st_d;
  logic [1:0]  lev_q, lev_d;
  logic [5:0]  vec_q, vec_d;
  logic        armed_q, armed_d;
  logic [3:0]  br_q, br_d;
  logic        sack_q, sack_d;
  logic        bbsy_q, bbsy_d;
  logic        intr_q, intr_d;
  logic [15:0] dout_q, dout_d;
  logic        done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        clr;

  assign clr = RESET | init_in_h;

`ifdef KY11_INTR_TIMEOUT_EN
  localparam int TW = $clog2(SSYNTIMO + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timo_q, timo_set, timo_clr;
`endif

  // Next-state and next-output logic for the bus transaction
  always_comb begin
    st_d    = st_q;
    lev_d   = lev_q;
    vec_d   = vec_q;
    armed_d = armed_q;
    br_d    = br_q;
    sack_d  = sack_q;
    bbsy_d  = bbsy_q;
    intr_d  = intr_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef KY11_INTR_TIMEOUT_EN
    tcnt_d   = tcnt_q;
    timo_set = 1'b0;
    timo_clr = 1'b0;
`endif
    unique case (st_q)
      IDLE: begin
        if (!armed_q && irqlev != {1'b1, lev_q})
          armed_d = 1'b1;
        if (armed_q && irqlev[2]) begin
          lev_d = irqlev[1:0];
          vec_d = irqvec;
          br_d  = 4'b0001 << irqlev[1:0];
          cnt_d = '0;
          st_d  = REQ;
        end
      end
      REQ: begin
        if (irqlev != {1'b1, lev_q}) begin
          br_d = '0;
          st_d = IDLE;
        end else if (!bg_in_l[lev_q]) begin
          if (cnt_q == CW'(GRDEBOUNCE)) begin
            sack_d = 1'b1;
            br_d   = '0;
            st_d   = GRANT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d = '0;
        end
      end
      GRANT: begin
        if (!bbsy_in_h && !syn_msyn_in_h &&
            !syn_ssyn_in_h && bg_in_l[lev_q]) begin
          bbsy_d = 1'b1;
          intr_d = 1'b1;
          dout_d = {8'b0, vec_q, 2'b00};
          sack_d = 1'b0;
`ifdef KY11_INTR_TIMEOUT_EN
          tcnt_d = '0;
`endif
          st_d   = WAITSSYN;
        end
      end
      WAITSSYN: begin
        if (del_ssyn_in_h) begin
          intr_d = 1'b0;
          st_d   = RELEASE;
        end
`ifdef KY11_INTR_TIMEOUT_EN
        else if (tcnt_q == TW'(SSYNTIMO - 1)) begin
          intr_d   = 1'b0;
          bbsy_d   = 1'b0;
          dout_d   = '0;
          armed_d  = 1'b0;
          timo_set = 1'b1;
          st_d     = IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      RELEASE: begin
        if (!del_ssyn_in_h) begin
          bbsy_d  = 1'b0;
          dout_d  = '0;
          done_d  = 1'b1;
          armed_d = 1'b0;
`ifdef KY11_INTR_TIMEOUT_EN
          timo_clr = 1'b1;
`endif
          st_d    = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // State and registered outputs; INIT clears like RESET
  always_ff @(posedge CLOCK) begin
    if (clr) begin
      st_q    <= IDLE;
      lev_q   <= '0;
      vec_q   <= '0;
      armed_q <= 1'b1;
      br_q    <= '0;
      sack_q  <= 1'b0;
      bbsy_q  <= 1'b0;
      intr_q  <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      lev_q   <= lev_d;
      vec_q   <= vec_d;
      armed_q <= armed_d;
      br_q    <= br_d;
      sack_q  <= sack_d;
      bbsy_q  <= bbsy_d;
      intr_q  <= intr_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef KY11_INTR_TIMEOUT_EN
  // SSYN timer and sticky timeout flag; INIT leaves the flag alone
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      tcnt_q <= '0;
      timo_q <= 1'b0;
    end else if (init_in_h) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      if (timo_set)
        timo_q <= 1'b1;
      else if (timo_clr)
        timo_q <= 1'b0;
    end
  end
  assign intrtimo = timo_q;
`else
  assign intrtimo = 1'b0;
`endif

  // Block grants at our own level while requesting or holding the bus
  always_comb begin
    bg_out_l = bg_in_l;
    if (!clr) begin
      bg_out_l = bg_in_l | br_q;
      if (st_q == GRANT || st_q == WAITSSYN || st_q == RELEASE)
        bg_out_l[lev_q] = 1'b1;
    end
  end

  assign br_out_h   = br_q;
  assign sack_out_h = sack_q;
  assign bbsy_out_h = bbsy_q;
  assign intr_out_h = intr_q;
  assign d_out_h    = dout_q;
  assign irqdone    = done_q;
  assign istate     = st_q;

endmodule
